// File: rtl/i2c_write_queue_pkg.sv
// i2c_write_queue_pkg: shared widths, FSM state encoding and queue entry layout
// for the I2C write queue.
package i2c_write_queue_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
  localparam int ENTRY_W    = I2C_ADDR_W + I2C_DATA_W;

  // Launch/handshake FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // One queued write: address in the upper bits, data byte in the lower.
  typedef struct packed {
    logic [I2C_ADDR_W-1:0] addr;
    logic [I2C_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/i2c_write_queue_if.sv
// i2c_write_queue_if: host request/response channels plus the bus-block
// launch/completion signals. 'slave' is the queue's view, 'master' is the
// view of whatever drives it (host and bus block together).
interface i2c_write_queue_if #(
  parameter int AW = 3
);
  import i2c_write_queue_pkg::*;

  // Host request channel
  logic                  wr_valid;
  logic                  wr_ready;
  logic [I2C_ADDR_W-1:0] wr_addr;
  logic [I2C_DATA_W-1:0] wr_data;

  // Bus block side
  logic                  go;
  logic [I2C_ADDR_W-1:0] addrIn;
  logic [I2C_DATA_W-1:0] Data;
  logic                  done;
  logic                  success;

  // Host response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_ok;
  logic                  rsp_tmo;
  logic [I2C_ADDR_W-1:0] rsp_addr;

  // Occupancy
  logic [AW:0]           level;

  modport slave (
    input  wr_valid, wr_addr, wr_data, done, success, rsp_ready,
    output wr_ready, go, addrIn, Data, rsp_valid, rsp_ok, rsp_tmo, rsp_addr, level
  );

  modport master (
    output wr_valid, wr_addr, wr_data, done, success, rsp_ready,
    input  wr_ready, go, addrIn, Data, rsp_valid, rsp_ok, rsp_tmo, rsp_addr, level
  );

endinterface

// File: rtl/i2c_sync_fifo.sv
// i2c_sync_fifo: single-clock FIFO with a registered read head. dout is
// loaded on pop and held until the next pop, so it can drive the bus block
// directly for the whole transaction.
module i2c_sync_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the registered count, so a pop in the same cycle
  // never opens a slot for a push until the next cycle.
  assign full    = (count == FULL_LVL);
  assign empty   = (count == '0);
  assign level   = count;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage write
  // NOTE: the storage array has no reset; contents are only ever read
  // behind the count, so clearing it would buy nothing.
  always_ff @(posedge mclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and registered read head
  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2c_write_queue.sv
// i2c_write_queue: buffers host writes and launches them one at a time on the
// I2C master bus block, returning one ACK/NACK/timeout response per write.
// Optional feature macro: I2C_RETRY_EN -- when defined, a NACKed write is
// re-issued up to MAX_RETRY extra times before its response is returned.
module i2c_write_queue
  import i2c_write_queue_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
`ifdef I2C_RETRY_EN
  parameter int MAX_RETRY   = 2,
`endif
  parameter int TIMEOUT_CYC = 4096
) (
  input logic              mclk,
  input logic              rst,
  i2c_write_queue_if.slave bus
);

  localparam int            TW         = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  state_t                state;
  state_t                state_nxt;
  entry_t                wr_entry;
  entry_t                head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  done_q;
  logic                  done_rise;
  logic                  retry_ok;
  logic [TW-1:0]         timer;
  logic                  rsp_ok_q;
  logic                  rsp_tmo_q;
  logic [I2C_ADDR_W-1:0] rsp_addr_q;

  assign wr_entry = '{addr: bus.wr_addr, data: bus.wr_data};

  i2c_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .mclk  (mclk),
    .rst   (rst),
    .push  (bus.wr_valid),
    .din   (wr_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (bus.level)
  );

  assign bus.wr_ready = !fifo_full;
  // The head register only changes on pop, so address/data stay put from
  // go through done, including across re-issues.
  assign bus.addrIn   = head.addr;
  assign bus.Data     = head.data;
  assign bus.rsp_ok   = rsp_ok_q;
  assign bus.rsp_tmo  = rsp_tmo_q;
  assign bus.rsp_addr = rsp_addr_q;

  // A done that is already high when WAIT is entered is not a completion;
  // only a low-to-high transition counts.
  assign done_rise = bus.done && !done_q;

`ifdef I2C_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [RW-1:0] retry_cnt;

  // Retry counter: cleared on every pop, bumped on each re-issue after a NACK
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if (pop) begin
      retry_cnt <= '0;
    end else if (state == WAIT && state_nxt == ISSUE) begin
      retry_cnt <= retry_cnt + RW'(1);
    end
  end

  assign retry_ok = (retry_cnt < RW'(MAX_RETRY));
`else
  assign retry_ok = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic
  // NOTE: every combinational output gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!fifo_empty) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (done_rise) begin
          state_nxt = (!bus.success && retry_ok) ? ISSUE : RESP;
        end else if (timer == TIMER_LAST) begin
          state_nxt = RESP;
        end
      end
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: launch pulse, response valid, FIFO pop
  always_comb begin
    bus.go        = 1'b0;
    bus.rsp_valid = 1'b0;
    pop           = 1'b0;
    case (state)
      IDLE:    pop           = !fifo_empty;
      ISSUE:   bus.go        = 1'b1;
      RESP:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Done edge history, WAIT timer and response capture
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      done_q     <= 1'b0;
      timer      <= '0;
      rsp_ok_q   <= 1'b0;
      rsp_tmo_q  <= 1'b0;
      rsp_addr_q <= '0;
    end else begin
      done_q <= bus.done;
      if (state == ISSUE)     timer <= '0;
      else if (state == WAIT) timer <= timer + TW'(1);
      if (state == WAIT && state_nxt == RESP) begin
        rsp_ok_q   <= done_rise && bus.success;
        rsp_tmo_q  <= !done_rise;
        rsp_addr_q <= head.addr;
      end
    end
  end

endmodule
